// File: rtl/key_debounce.sv
// Debounced reader for N_KEY active-low keys: 2-flop sync, stability counter, level + press/release pulses.
// Optional auto-repeat of key_press while held is built when KEY_REPEAT_EN is defined.
module key_debounce #(
    parameter int N_KEY   = 4,
    parameter int DEB_CYC = 1000000,
    parameter int REP_DLY = 25000000,
    parameter int REP_PER = 5000000
) (
    input  logic             clk,
    input  logic             res,
    input  logic [N_KEY-1:0] key_n,
    output logic [N_KEY-1:0] key_state,
    output logic [N_KEY-1:0] key_press,
    output logic [N_KEY-1:0] key_release
);

    localparam int CW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

    logic [N_KEY-1:0] s1, s2;
    logic [N_KEY-1:0] p;
    logic [N_KEY-1:0] hit;
    logic [N_KEY-1:0] rep_fire;
    logic [CW-1:0]    cnt [N_KEY];

    assign p = ~s2;

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < N_KEY; i++) begin
            hit[i] = (p[i] != key_state[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            s1          <= '1;
            s2          <= '1;
            key_state   <= '0;
            key_press   <= '0;
            key_release <= '0;
            for (int unsigned i = 0; i < N_KEY; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1          <= key_n;
            s2          <= s1;
            key_press   <= (hit & p) | rep_fire;
            key_release <= hit & ~p;
            for (int unsigned i = 0; i < N_KEY; i++) begin
                if (p[i] == key_state[i]) begin
                    cnt[i] <= '0;
                end else if (hit[i]) begin
                    key_state[i] <= p[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DLY_MAX = RW'(REP_DLY - 1);
    localparam logic [RW-1:0] PER_MAX = RW'(REP_PER - 1);

    logic [RW-1:0]    rcnt [N_KEY];
    logic [N_KEY-1:0] rep_on;

    // A release accepted this cycle (hit while key_state=1) suppresses any repeat.
    always_comb begin
        rep_fire = '0;
        for (int unsigned i = 0; i < N_KEY; i++) begin
            rep_fire[i] = key_state[i] && !hit[i] &&
                          (rep_on[i] ? (rcnt[i] == PER_MAX) : (rcnt[i] == DLY_MAX));
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rep_on <= '0;
            for (int unsigned i = 0; i < N_KEY; i++) begin
                rcnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_KEY; i++) begin
                if (!key_state[i] || hit[i]) begin
                    rcnt[i]   <= '0;
                    rep_on[i] <= 1'b0;
                end else if (rep_fire[i]) begin
                    rcnt[i]   <= '0;
                    rep_on[i] <= 1'b1;
                end else begin
                    rcnt[i] <= rcnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign rep_fire = '0;

    // Repeat timing parameters only matter with the repeat feature built; keep them referenced.
    if (REP_DLY < 1 || REP_PER < 1) begin : g_rep_param_unused
    end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Randomized + directed bench for key_debounce against a sliding-window reference model.
// Repeat expectations follow KEY_REPEAT_EN (REP_DLY=10, REP_PER=3).
module tb_key_debounce;

    localparam int N       = 4;
    localparam int DEB     = 4;
    localparam int REP_DLY = 10;
    localparam int REP_PER = 3;
    localparam int HL      = DEB + 2;

    logic         clk = 1'b0;
    logic         res = 1'b0;
    logic [N-1:0] key_n = '0;
    logic [N-1:0] key_state, key_press, key_release;

    int n_checks = 0;
    int n_errors = 0;

    // Model: raw samples history, hist[0] newest
    logic [N-1:0] hist [HL];
    logic [N-1:0] exp_state = '0;
    logic [N-1:0] exp_press = '0;
    logic [N-1:0] exp_rel   = '0;
`ifdef KEY_REPEAT_EN
    int held [N];
`endif

    key_debounce #(
        .N_KEY  (N),
        .DEB_CYC(DEB),
        .REP_DLY(REP_DLY),
        .REP_PER(REP_PER)
    ) dut (
        .clk        (clk),
        .res        (res),
        .key_n      (key_n),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    // The filter at edge t sees key_n sampled at edge t-2; a level is accepted
    // when the last DEB filter samples all agree and differ from the current state.
    always @(posedge clk) begin
        if (!res) begin
            for (int k = 0; k < HL; k++) hist[k] = '1;
            exp_state = '0;
            exp_press = '0;
            exp_rel   = '0;
`ifdef KEY_REPEAT_EN
            for (int j = 0; j < N; j++) held[j] = 0;
`endif
        end else begin
            for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0]   = key_n;
            exp_press = '0;
            exp_rel   = '0;
            for (int j = 0; j < N; j++) begin
                logic same;
                logic pv;
                same = 1'b1;
                for (int k = 2; k < HL; k++) if (hist[k][j] != hist[2][j]) same = 1'b0;
                pv = ~hist[2][j];
                if (same && pv != exp_state[j]) begin
                    exp_state[j] = pv;
                    if (pv) exp_press[j] = 1'b1;
                    else    exp_rel[j]   = 1'b1;
`ifdef KEY_REPEAT_EN
                    held[j] = 0;
`endif
                end
`ifdef KEY_REPEAT_EN
                else if (exp_state[j]) begin
                    held[j]++;
                    if (held[j] >= REP_DLY && (held[j] - REP_DLY) % REP_PER == 0)
                        exp_press[j] = 1'b1;
                end
`endif
            end
        end
    end

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("state",   key_state,               exp_state);
        check("press",   key_press,               exp_press);
        check("release", key_release,             exp_rel);
        check("excl",    key_press & key_release, '0);
    endtask

    task automatic cycle(input logic [N-1:0] kn);
        @(negedge clk);
        check_outputs();
        key_n = kn;
    endtask

    task automatic hold(input logic [N-1:0] kn, input int n);
        repeat (n) cycle(kn);
    endtask

    task automatic reset_pulse(input int n, input logic [N-1:0] kn);
        @(negedge clk);
        check_outputs();
        key_n = kn;
        res   = 1'b0;
        #1;
        check("rst_state",   key_state,   '0);
        check("rst_press",   key_press,   '0);
        check("rst_release", key_release, '0);
        repeat (n) begin
            @(negedge clk);
            check_outputs();
        end
        res = 1'b1;
    endtask

    initial begin
        logic [N-1:0] kn;
        logic [N-1:0] mask;
        logic [N-1:0] p_seen;

        // Reset with all keys held, then release reset
        for (int k = 0; k < HL; k++) hist[k] = '1;
        #1;
        check("por_state", key_state, '0);
        check("por_press", key_press, '0);
        repeat (3) @(negedge clk);
        res = 1'b1;
        p_seen = '0;
        repeat (8) begin
            cycle(4'b0000);
            p_seen |= key_press;
        end
        check("all_pressed_seen", p_seen, 4'b1111);

        // Clean release of all, clean press/release of key 0
        hold(4'b1111, 10);
        hold(4'b1110, 10);
        hold(4'b1111, 10);

        // Bounce on key 1 (three-cycle lows), then stable low
        for (int r = 0; r < 2; r++) begin
            hold(4'b1101, 3);
            hold(4'b1111, 1);
        end
        hold(4'b1101, 10);
        hold(4'b1111, 10);

        // Keys 2 and 3 together
        hold(4'b0011, 10);
        hold(4'b1111, 10);

        // Reset mid-hold on key 0
        hold(4'b1110, 10);
        reset_pulse(1, 4'b1110);
        hold(4'b1110, 10);
        hold(4'b1111, 10);

        // Long hold for auto-repeat, then release
        hold(4'b1110, 30);
        hold(4'b1111, 12);

        // Random toggling: bounces, overlaps and occasional resets
        kn = 4'b1111;
        for (int c = 0; c < 1500; c++) begin
            mask = '0;
            for (int j = 0; j < N; j++) if ($urandom_range(0, 6) == 0) mask[j] = 1'b1;
            kn ^= mask;
            if ($urandom_range(0, 299) == 0) reset_pulse($urandom_range(1, 3), kn);
            else                             cycle(kn);
        end
        hold(4'b1111, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounced push-button reader for the board's user keys. It is the input-side counterpart to the LED output drivers. Each of `N_KEY` active-low mechanical keys passes through a two-flop synchronizer and a per-key stability counter. The block produces a clean level plus single-cycle press and release pulses, which the LED pattern logic consumes as user commands. All keys are handled independently and in parallel.

## Interface
- `N_KEY`, default 4: number of keys.
- `DEB_CYC`, default 1000000: stable-sample cycles needed to accept a level change (20 ms at 50 MHz). Must be ≥ 2.
- `REP_DLY`, default 25000000: held cycles before the first auto-repeat (`KEY_REPEAT_EN` only).
- `REP_PER`, default 5000000: cycles between subsequent auto-repeats (`KEY_REPEAT_EN` only).
- `clk`  input  1  system clock.
- `res`  input  1  reset; one clock; reset is asynchronous and active-low.
- `key_n`  input  N_KEY  raw key pins; 0 = pressed; asynchronous to `clk`.
- `key_state`  output  N_KEY  debounced level; 1 = pressed.
- `key_press`  output  N_KEY  one-cycle pulse on an accepted press (and on each repeat).
- `key_release`  output  N_KEY  one-cycle pulse on an accepted release.

## Operation
- Synchronizer per key: `s1 <= key_n[i]`, then `s2 <= s1`. The filter sees `p = ~s2` (1 = pressed).
- Per-key counter `cnt` has width `$clog2(DEB_CYC)`. On each edge:
  - If `p == key_state[i]`: `cnt <= 0`. Any single agreeing sample restarts the count, which is what rejects bounce.
  - Else if `cnt == DEB_CYC-1`: `key_state[i] <= p`, `cnt <= 0`, and pulse `key_press[i]` if `p == 1`, otherwise `key_release[i]`.
  - Else: `cnt <= cnt + 1`.
- Every output is registered; pulses are exactly one cycle wide.
- Keys never interact. Any combination of pulses may assert in the same cycle.
- A press and a release of the same key can never pulse in the same cycle.
- The counter cannot wrap: it is cleared at `DEB_CYC-1` or whenever the sampled level agrees with `key_state`.

## Timing
- Reset values:
  - `s1`, `s2` = all 1 (released).
  - `key_state`, `key_press`, `key_release` = 0.
  - All counters = 0.
- Latency: let edge 0 be the first edge at which `s1` captures a new stable level. The corresponding pulse and `key_state` change are visible after edge `DEB_CYC+1`.
  - Example: `DEB_CYC=4` gives a pulse after edge 5.
- Minimum accepted pulse width on `key_n` is `DEB_CYC` consecutive samples. Shorter events are ignored completely.
- Reset asserted mid-count or mid-hold: all state clears immediately and no pulses are emitted. A key still held after reset release is treated as a new press, with a pulse after `DEB_CYC+1` edges.

## Configuration
- Macro: `KEY_REPEAT_EN`.
- Defined: each key has a repeat counter, cleared whenever `key_state[i]==0` and reset to 0 on the accepted press.
  - After `REP_DLY` cycles of continuous accepted hold, `key_press[i]` pulses again.
  - Further pulses follow every `REP_PER` cycles until release.
  - A release stops repeats immediately; no repeat pulse may coincide with `key_release[i]`.
- Undefined: there is exactly one `key_press` pulse per accepted press. `REP_DLY` and `REP_PER` are ignored and no repeat logic is built.

## Test plan
All scenarios use `DEB_CYC=4` unless stated.
- Reset: hold `res=0` with `key_n=4'b0000` → all outputs 0. Release `res` → `key_press=4'b1111` for one cycle after edge 5, and `key_state=4'b1111`.
- Clean press and release: `key_n[0]` goes 1→0 stable → `key_press[0]` pulses after edge 5. Later 0→1 stable → `key_release[0]` pulses after edge 5, and `key_state[0]=0`.
- Bounce rejection: `key_n[1]` reads 0,0,0,1,0,0,0,1 (three-cycle lows) → no pulse and `key_state[1]` stays 0. It then holds 0 → pulse 4 edges after the last 1 is synchronized.
- Simultaneous keys: `key_n[2]` and `key_n[3]` fall on the same edge → both `key_press` bits pulse in the same cycle.
- Reset mid-hold: key 0 accepted, then `res` pulses low for 1 cycle with the key still held → `key_state` is 0 during reset. After release, `key_press[0]` pulses again after edge 5 and `key_release` stays silent.
- Repeat (`KEY_REPEAT_EN`, `REP_DLY=10`, `REP_PER=3`): hold key 0 → pulses at acceptance, +10, +13, +16 cycles. On release, the repeat pulses stop and a single `key_release[0]` pulse follows.
